// File: rtl/operand_fetch_pkg.sv
// Shared constants and types for the operand fetch stage.
package operand_fetch_pkg;

    localparam int unsigned WIDTH          = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned REG_COUNT      = 32;
    localparam int unsigned PENDING_WIDTH  = 2;
    localparam int          PENDING_MAX    = (1 << PENDING_WIDTH) - 1;

    typedef logic [PENDING_WIDTH-1:0] pending_t;

    typedef struct packed {
        logic [WIDTH-1:0]          rs_data;
        logic [WIDTH-1:0]          rt_data;
        logic [REG_ADDR_WIDTH-1:0] dest_address;
        logic                      dest_write;
    } ex_reg_t;

endpackage

// File: rtl/operand_fetch_regfile_bypass.sv
// Register file, two combinational read ports with write-through bypass, one write port.
module regfile_bypass
    import operand_fetch_pkg::*;
(
    input  logic                                clk,
    input  logic                                nrst,
    input  logic                                wr_en,
    input  logic [REG_ADDR_WIDTH-1:0]           wr_address,
    input  logic [WIDTH-1:0]                    wr_data,
    input  logic [REG_ADDR_WIDTH-1:0]           rd_address_a,
    output logic [WIDTH-1:0]                    rd_data_a,
    input  logic [REG_ADDR_WIDTH-1:0]           rd_address_b,
    output logic [WIDTH-1:0]                    rd_data_b,
    output logic [REG_COUNT-2:0][WIDTH-1:0]     regs
);

    // Register 0 is hardwired to zero, so only registers 1..REG_COUNT-1 are stored.
    logic [REG_COUNT-2:0][WIDTH-1:0] regs_q;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            regs_q <= '0;
        end else if (wr_en && (wr_address != '0)) begin
            regs_q[wr_address - 1'b1] <= wr_data;
        end
    end

    assign rd_data_a = (rd_address_a == '0) ? '0 :
                       (wr_en && (wr_address == rd_address_a)) ? wr_data :
                       regs_q[rd_address_a - 1'b1];

    assign rd_data_b = (rd_address_b == '0) ? '0 :
                       (wr_en && (wr_address == rd_address_b)) ? wr_data :
                       regs_q[rd_address_b - 1'b1];

    assign regs = regs_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: register file read, pending-writer scoreboard and the execute register.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic                            clk,
    input  logic                            nrst,
    input  logic                            id_valid,
    output logic                            id_ready,
    input  logic [REG_ADDR_WIDTH-1:0]       rs_address,
    input  logic [REG_ADDR_WIDTH-1:0]       rt_address,
    input  logic [REG_ADDR_WIDTH-1:0]       dest_address,
    input  logic                            dest_write,
    input  logic                            rd_wb,
    input  logic [REG_ADDR_WIDTH-1:0]       rd_address_wb,
    input  logic [WIDTH-1:0]                rd_data_wb,
    input  logic                            flush,
    output logic                            ex_valid,
    input  logic                            ex_ready,
    output logic [WIDTH-1:0]                rs_data_ex,
    output logic [WIDTH-1:0]                rt_data_ex,
    output logic [REG_ADDR_WIDTH-1:0]       dest_address_ex,
    output logic                            dest_write_ex,
    output logic [REG_COUNT-2:0][WIDTH-1:0] reg_file
);

    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;

    regfile_bypass u_regfile (
        .clk          (clk),
        .nrst         (nrst),
        .wr_en        (rd_wb),
        .wr_address   (rd_address_wb),
        .wr_data      (rd_data_wb),
        .rd_address_a (rs_address),
        .rd_data_a    (rs_data),
        .rd_address_b (rt_address),
        .rd_data_b    (rt_data),
        .regs         (reg_file)
    );

    pending_t pending_q [REG_COUNT];
    pending_t pending_d [REG_COUNT];
    ex_reg_t  ex_q;
    logic     ex_valid_q;

    logic rs_hazard;
    logic rt_hazard;
    logic dest_full;
    logic ex_free;
    logic issue;

    // A source being written back this cycle is satisfied by the bypass path.
    assign rs_hazard = (rs_address != '0) && (pending_q[rs_address] != '0) &&
                       !(rd_wb && (rd_address_wb == rs_address));
    assign rt_hazard = (rt_address != '0) && (pending_q[rt_address] != '0) &&
                       !(rd_wb && (rd_address_wb == rt_address));
    assign dest_full = dest_write && (dest_address != '0) &&
                       (int'(pending_q[dest_address]) == PENDING_MAX);

    assign ex_free  = !ex_valid_q || ex_ready || flush;
    assign id_ready = ex_free && !rs_hazard && !rt_hazard && !dest_full;
    assign issue    = id_valid && id_ready;

    always_comb begin
        int cnt;
        cnt = 0;
        pending_d[0] = '0;
        for (int r = 1; r < REG_COUNT; r++) begin
            cnt = int'(pending_q[r]);
            if (issue && dest_write && (dest_address == REG_ADDR_WIDTH'(r))) begin
                cnt = cnt + 1;
            end
            if (rd_wb && (rd_address_wb == REG_ADDR_WIDTH'(r))) begin
                cnt = cnt - 1;
            end
            if (flush && ex_valid_q && ex_q.dest_write &&
                (ex_q.dest_address == REG_ADDR_WIDTH'(r))) begin
                cnt = cnt - 1;
            end
            // Stray writebacks at zero must not wrap the count.
            if (cnt < 0) begin
                cnt = 0;
            end else if (cnt > PENDING_MAX) begin
                cnt = PENDING_MAX;
            end
            pending_d[r] = PENDING_WIDTH'(cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            pending_q <= '{default: '0};
        end else begin
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
        end else if (issue) begin
            ex_valid_q        <= 1'b1;
            ex_q.rs_data      <= rs_data;
            ex_q.rt_data      <= rt_data;
            ex_q.dest_address <= dest_address;
            ex_q.dest_write   <= dest_write;
        end else if (ex_free) begin
            ex_valid_q <= 1'b0;
        end
    end

    assign ex_valid        = ex_valid_q;
    assign rs_data_ex      = ex_q.rs_data;
    assign rt_data_ex      = ex_q.rt_data;
    assign dest_address_ex = ex_q.dest_address;
    assign dest_write_ex   = ex_q.dest_write;

endmodule
